// File: rtl/spart_pkg.sv
// Shared types and SPART register addresses for the bus scheduler.
package spart_pkg;

   typedef enum logic [2:0] {
      CFG_LO  = 3'd0,
      CFG_HI  = 3'd1,
      IDLE    = 3'd2,
      RX      = 3'd3,
      TX_LO   = 3'd4,
      TX_WAIT = 3'd5,
      TX_HI   = 3'd6
   } state_t;

   localparam logic [1:0] ADDR_DATA   = 2'b00;
   localparam logic [1:0] ADDR_STATUS = 2'b01;
   localparam logic [1:0] ADDR_DB_LO  = 2'b10;
   localparam logic [1:0] ADDR_DB_HI  = 2'b11;

endpackage

// File: rtl/spart_rx_assembler.sv
// Pairs received bytes into 16-bit words (low byte first); a lone low byte
// is dropped after RX_TIMEOUT cycles with no second read.
module spart_rx_assembler
   import spart_pkg::*;
#(
   parameter int RX_TIMEOUT = 1023
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_strobe,
   input  logic [7:0]  i_byte,
   output logic [15:0] o_word,
   output logic        o_valid
);

   localparam int TW = (RX_TIMEOUT > 1) ? $clog2(RX_TIMEOUT) : 1;

   logic [TW-1:0] r_tmo_cnt;
   logic          r_have_lo;
   logic [7:0]    r_lo;
   logic [15:0]   r_word;
   logic          r_valid;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_tmo_cnt <= '0;
         r_have_lo <= 1'b0;
         r_lo      <= 8'h00;
         r_word    <= 16'h0000;
         r_valid   <= 1'b0;
      end else begin
         r_valid <= 1'b0;
         if (i_strobe) begin
            if (r_have_lo) begin
               r_word    <= {i_byte, r_lo};
               r_valid   <= 1'b1;
               r_have_lo <= 1'b0;
            end else begin
               r_lo      <= i_byte;
               r_have_lo <= 1'b1;
            end
            r_tmo_cnt <= '0;
         end else if (r_have_lo) begin
            // The last idle cycle of the window discards the pending low byte.
            if (r_tmo_cnt == TW'(RX_TIMEOUT - 1)) begin
               r_have_lo <= 1'b0;
               r_tmo_cnt <= '0;
            end else begin
               r_tmo_cnt <= r_tmo_cnt + 1'b1;
            end
         end
      end
   end

   assign o_word  = r_word;
   assign o_valid = r_valid;

endmodule

// File: rtl/spart_bus_sched.sv
// SPART bus scheduler: programs the baud divisor, then arbitrates two
// transmit requesters round-robin and services receive-data reads.
module spart_bus_sched
   import spart_pkg::*;
#(
   parameter logic [15:0] DIVISOR    = 16'd325,
   parameter int          RX_TIMEOUT = 1023
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [1:0]  req,
   input  logic [15:0] word0,
   input  logic [15:0] word1,
   output logic [1:0]  grant,
   input  logic        rda,
   input  logic        tbr,
   output logic        iocs,
   output logic        iorw,
   output logic [1:0]  ioaddr,
   output logic [7:0]  tx_byte,
   output logic        db_oe,
   input  logic [7:0]  rx_byte,
   output logic [15:0] rx_word,
   output logic        rx_valid,
   output logic        busy
);

   state_t      r_state, w_next;
   logic [15:0] r_word;
   logic        r_rr_ptr;
   logic        r_tx_pend;
   logic        r_wait_met;
   logic [1:0]  w_win, w_grant, w_ioaddr;
   logic        w_iocs, w_iorw, w_db_oe;
   logic [7:0]  w_tx_byte;

   // r_rr_ptr selects the requester favoured when both are asking.
   assign w_win = (req == 2'b11) ? (r_rr_ptr ? 2'b10 : 2'b01) : req;

   always_comb begin
      w_next    = r_state;
      w_grant   = 2'b00;
      w_iocs    = 1'b0;
      w_iorw    = 1'b1;
      w_ioaddr  = ADDR_STATUS;
      w_db_oe   = 1'b0;
      w_tx_byte = 8'h00;
      case (r_state)
         CFG_LO: begin
            w_iocs = 1'b1; w_iorw = 1'b0; w_ioaddr = ADDR_DB_LO;
            w_db_oe = 1'b1; w_tx_byte = DIVISOR[7:0];
            w_next = CFG_HI;
         end
         CFG_HI: begin
            w_iocs = 1'b1; w_iorw = 1'b0; w_ioaddr = ADDR_DB_HI;
            w_db_oe = 1'b1; w_tx_byte = DIVISOR[15:8];
            w_next = IDLE;
         end
         IDLE: begin
            if (rda) begin
               w_next = RX;
            end else if (tbr && (req != 2'b00) && !r_tx_pend) begin
               w_grant = w_win;
               w_next  = TX_LO;
            end
         end
         RX: begin
            w_iocs = 1'b1; w_ioaddr = ADDR_DATA;
            w_next = r_tx_pend ? TX_WAIT : IDLE;
         end
         TX_LO: begin
            w_iocs = 1'b1; w_iorw = 1'b0; w_ioaddr = ADDR_DATA;
            w_db_oe = 1'b1; w_tx_byte = r_word[7:0];
            w_next = TX_WAIT;
         end
         TX_WAIT: begin
            if (rda)                     w_next = RX;
            else if (r_wait_met && tbr)  w_next = TX_HI;
         end
         TX_HI: begin
            w_iocs = 1'b1; w_iorw = 1'b0; w_ioaddr = ADDR_DATA;
            w_db_oe = 1'b1; w_tx_byte = r_word[15:8];
            w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= CFG_LO;
         r_word     <= 16'h0000;
         r_rr_ptr   <= 1'b0;
         r_tx_pend  <= 1'b0;
         r_wait_met <= 1'b0;
      end else begin
         r_state <= w_next;
         if (w_grant != 2'b00) begin
            r_word    <= w_grant[1] ? word1 : word0;
            r_rr_ptr  <= w_grant[0];
            r_tx_pend <= 1'b1;
         end
         // The first TX_WAIT cycle arms the exit; an RX detour keeps it armed.
         if (r_state == TX_LO)   r_wait_met <= 1'b0;
         if (r_state == TX_WAIT) r_wait_met <= 1'b1;
         if (r_state == TX_HI)   r_tx_pend  <= 1'b0;
      end
   end

   spart_rx_assembler #(
      .RX_TIMEOUT (RX_TIMEOUT)
   ) u_rx_asm (
      .clk      (clk),
      .rst      (rst),
      .i_strobe (r_state == RX),
      .i_byte   (rx_byte),
      .o_word   (rx_word),
      .o_valid  (rx_valid)
   );

   // While reset is held the bus must look idle, not like a CFG_LO write.
   assign grant   = rst ? w_grant : 2'b00;
   assign iocs    = rst & w_iocs;
   assign iorw    = ~rst | w_iorw;
   assign ioaddr  = rst ? w_ioaddr : ADDR_STATUS;
   assign db_oe   = rst & w_db_oe;
   assign tx_byte = rst ? w_tx_byte : 8'h00;
   assign busy    = (r_state != IDLE);

endmodule

// File: tb/tb_spart_bus_sched.sv
// Bench for spart_bus_sched: directed scenarios plus a randomized run, all
// checked by a transaction-level bus model.
module tb_spart_bus_sched;

   localparam logic [15:0] DIV = 16'd325;
   localparam int          TMO = 1023;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [1:0]  req = 2'b00;
   logic [15:0] word0 = 16'h0, word1 = 16'h0;
   logic        rda = 1'b0, tbr = 1'b0;
   logic [7:0]  rx_byte = 8'h00;
   logic [1:0]  grant, ioaddr;
   logic        iocs, iorw, db_oe, rx_valid, busy;
   logic [7:0]  tx_byte;
   logic [15:0] rx_word;

   always #5 clk = ~clk;

   spart_bus_sched #(.DIVISOR(DIV), .RX_TIMEOUT(TMO)) dut (
      .clk(clk), .rst(rst), .req(req), .word0(word0), .word1(word1),
      .grant(grant), .rda(rda), .tbr(tbr), .iocs(iocs), .iorw(iorw),
      .ioaddr(ioaddr), .tx_byte(tx_byte), .db_oe(db_oe), .rx_byte(rx_byte),
      .rx_word(rx_word), .rx_valid(rx_valid), .busy(busy)
   );

   int n_chk = 0, n_fail = 0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   // Model state
   logic [7:0]  txq[$];
   logic        rr_ptr, lo_have, exp_valid, exp_read, exp_write, hi_pend;
   logic [7:0]  lo_byte;
   logic [15:0] exp_word;
   int          idle_cnt, wait_n, since, cyc, lo_cyc, hi_cyc;
   int          n_grants = 0, n_valid = 0, ndata_at_valid = 0, n_cfg_wr = 0;
   logic [1:0]  grant_log[$];
   logic [7:0]  data_log[$];
   logic [1:0]  last_grant = 2'b00;

   always @(negedge clk) begin
      logic idle_bus, is_rd, is_wr, was_lo;
      logic [1:0] win, exp_g;
      logic [15:0] w;
      cyc++;
      if (!rst) begin
         chk("rst_bus", {grant, iocs, iorw, ioaddr, db_oe, tx_byte, rx_valid},
             {2'b00, 1'b0, 1'b1, 2'b01, 1'b0, 8'h00, 1'b0});
         chk("rst_rx_word", rx_word, 16'h0000);
         txq.delete();
         rr_ptr = 1'b0; lo_have = 1'b0; idle_cnt = 0; exp_valid = 1'b0;
         exp_word = 16'h0000; exp_read = 1'b0; exp_write = 1'b0;
         hi_pend = 1'b0; wait_n = 0; since = 0;
      end else begin
         idle_bus = !iocs && iorw && ioaddr == 2'b01 && !db_oe && tx_byte == 8'h00;
         is_rd    = iocs && iorw && ioaddr == 2'b00;
         is_wr    = iocs && !iorw && ioaddr == 2'b00;
         if (iocs && !iorw && ioaddr[1]) n_cfg_wr++;
         if (since == 0)
            chk("cfg_lo", {iocs, iorw, ioaddr, db_oe, tx_byte}, {1'b1, 1'b0, 2'b10, 1'b1, DIV[7:0]});
         else if (since == 1)
            chk("cfg_hi", {iocs, iorw, ioaddr, db_oe, tx_byte}, {1'b1, 1'b0, 2'b11, 1'b1, DIV[15:8]});
         else if (since == 2)
            chk("cfg_idle_busy", busy, 1'b0);
         if (since < 3) since++;

         chk("rx_valid", rx_valid, exp_valid);
         chk("rx_word", rx_word, exp_word);
         if (rx_valid) begin n_valid++; ndata_at_valid = data_log.size(); end
         chk("rd_sched", is_rd, exp_read);
         chk("wr_sched", is_wr, exp_write);
         if (idle_bus) chk("busy", busy, hi_pend);

         exp_valid = 1'b0;
         if (is_rd) begin
            chk("rd_oe", db_oe, 1'b0);
            if (lo_have) begin
               exp_word = {rx_byte, lo_byte}; exp_valid = 1'b1; lo_have = 1'b0;
            end else begin
               lo_byte = rx_byte; lo_have = 1'b1; idle_cnt = 0;
            end
         end else if (lo_have) begin
            idle_cnt++;
            if (idle_cnt >= TMO) lo_have = 1'b0;
         end

         if (is_wr) begin
            chk("wr_oe", db_oe, 1'b1);
            data_log.push_back(tx_byte);
            was_lo = (txq.size() == 2);
            if (txq.size() == 0) chk("wr_unexpected", 1, 0);
            else chk("tx_byte", tx_byte, txq.pop_front());
            if (was_lo) begin hi_pend = 1'b1; wait_n = 0; lo_cyc = cyc; end
            else begin hi_pend = 1'b0; hi_cyc = cyc; end
         end

         win   = (req == 2'b11) ? (rr_ptr ? 2'b10 : 2'b01) : req;
         exp_g = (idle_bus && !hi_pend && !rda && tbr) ? win : 2'b00;
         chk("grant", grant, exp_g);
         if (grant != 2'b00) begin
            n_grants++; grant_log.push_back(grant); last_grant = grant;
         end
         if (exp_g != 2'b00) begin
            rr_ptr = exp_g[0];
            w = exp_g[1] ? word1 : word0;
            txq.push_back(w[7:0]); txq.push_back(w[15:8]);
         end

         exp_read  = idle_bus && rda;
         exp_write = (exp_g != 2'b00);
         if (idle_bus && hi_pend) begin
            wait_n++;
            if (!rda && tbr && wait_n >= 2) exp_write = 1'b1;
         end
      end
   end

   task automatic step(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic wait_grant(input int maxc);
      int g0 = n_grants;
      for (int i = 0; i < maxc; i++) begin
         step(1);
         if (n_grants != g0) return;
      end
      chk("grant_timeout", 0, 1);
   endtask

   task automatic wait_writes(input int n, input int maxc);
      for (int i = 0; i < maxc; i++) begin
         if (data_log.size() >= n) return;
         step(1);
      end
      chk("write_timeout", data_log.size(), n);
   endtask

   task automatic wait_quiet(input int maxc);
      for (int i = 0; i < maxc; i++) begin
         step(1);
         if (txq.size() == 0 && !hi_pend && !busy) return;
      end
      chk("quiet_timeout", busy, 0);
   endtask

   task automatic rx_pulse(input logic [7:0] b);
      rx_byte = b; rda = 1'b1;
      step(1);
      rda = 1'b0;
      step(1);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int v0, dl0, c0, g_seen;
      step(3);
      rst = 1'b1;
      step(4);
      chk("boot_idle", busy, 1'b0);
      chk("boot_cfg_writes", n_cfg_wr, 2);

      // Both requesters held: alternating grants, requester 0 first.
      grant_log.delete(); data_log.delete();
      word0 = 16'h1111; word1 = 16'h2222; tbr = 1'b1; req = 2'b11;
      for (int i = 0; i < 80; i++) begin
         step(1);
         if (grant_log.size() >= 3) break;
      end
      req = 2'b00;
      wait_quiet(40);
      chk("rr_count", grant_log.size(), 3);
      if (grant_log.size() >= 3) begin
         chk("rr_g0", grant_log[0], 2'b01);
         chk("rr_g1", grant_log[1], 2'b10);
         chk("rr_g2", grant_log[2], 2'b01);
      end

      // Single word from requester 0 with tbr high.
      grant_log.delete(); data_log.delete();
      word0 = 16'hA55A; req = 2'b01; tbr = 1'b1;
      wait_grant(20);
      req = 2'b00;
      wait_quiet(40);
      chk("t1_grant", grant_log.size() > 0 ? grant_log[0] : 2'b00, 2'b01);
      chk("t1_nbytes", data_log.size(), 2);
      if (data_log.size() == 2) begin
         chk("t1_lo", data_log[0], 8'h5A);
         chk("t1_hi", data_log[1], 8'hA5);
      end
      chk("t1_gap", hi_cyc - lo_cyc, 3);
      chk("t1_idle", busy, 1'b0);

      // Receive during TX_WAIT, serviced before the high byte.
      grant_log.delete(); data_log.delete();
      v0 = n_valid;
      word1 = 16'hBEEF; req = 2'b10; tbr = 1'b1;
      wait_grant(20);
      req = 2'b00; tbr = 1'b0;
      wait_writes(1, 20);
      rx_pulse(8'h34);
      rx_pulse(8'h12);
      step(2);
      chk("t4_nbytes_held", data_log.size(), 1);
      tbr = 1'b1;
      wait_quiet(40);
      chk("t4_rx_word", rx_word, 16'h1234);
      chk("t4_nvalid", n_valid - v0, 1);
      chk("t4_valid_before_hi", ndata_at_valid, 1);
      if (data_log.size() == 2) begin
         chk("t4_lo", data_log[0], 8'hEF);
         chk("t4_hi", data_log[1], 8'hBE);
      end else chk("t4_nbytes", data_log.size(), 2);

      // Lone byte times out, following pair assembles cleanly.
      v0 = n_valid; tbr = 1'b0;
      rx_pulse(8'h77);
      step(1022);
      rx_pulse(8'hCD);
      rx_pulse(8'hAB);
      step(2);
      chk("t5_rx_word", rx_word, 16'hABCD);
      chk("t5_nvalid", n_valid - v0, 1);

      // Reset during TX_WAIT abandons the high byte and reruns configuration.
      data_log.delete();
      word0 = 16'h1357; req = 2'b01; tbr = 1'b1;
      wait_grant(20);
      req = 2'b00; tbr = 1'b0;
      wait_writes(1, 20);
      step(1);
      c0 = n_cfg_wr; dl0 = data_log.size();
      rst = 1'b0;
      step(2);
      rst = 1'b1; tbr = 1'b1;
      step(12);
      chk("t6_no_hi", data_log.size(), dl0);
      chk("t6_cfg_rerun", n_cfg_wr - c0, 2);
      chk("t6_idle", busy, 1'b0);

      // Randomized traffic.
      word0 = 16'($urandom); word1 = 16'($urandom);
      g_seen = n_grants;
      for (int i = 0; i < 4000; i++) begin
         if (n_grants != g_seen) begin
            g_seen = n_grants;
            req = req & ~last_grant;
            if (last_grant[0]) word0 = 16'($urandom);
            if (last_grant[1]) word1 = 16'($urandom);
         end
         if (!req[0] && $urandom_range(0, 3) == 0) req[0] = 1'b1;
         if (!req[1] && $urandom_range(0, 3) == 0) req[1] = 1'b1;
         tbr     = ($urandom_range(0, 3) != 0);
         rda     = ($urandom_range(0, 9) == 0);
         rx_byte = 8'($urandom);
         step(1);
      end
      req = 2'b00; rda = 1'b0; tbr = 1'b1;
      wait_quiet(40);
      chk("rand_drained", txq.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/spart_bus_sched.md
SPART_BUS_SCHED -- requirements
Module: spart_bus_sched

Interface
REQ-001 SHALL have parameter DIVISOR, default 325, the 16-bit baud divisor written at start-up (9600 baud).
REQ-002 SHALL have parameter RX_TIMEOUT, default 1023, the idle cycles after which a half-received word is discarded.
REQ-003 SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req  input  2  per-requester transmit request, level, held until granted.
REQ-006 SHALL have ports word0, word1  input  16  transmit word of requester 0 and 1; sampled on grant.
REQ-007 SHALL have port grant  output  2  one-hot, one-cycle pulse; the word is accepted on that cycle.
REQ-008 SHALL have ports rda, tbr  input  1  SPART receive-data-available and transmit-buffer-ready.
REQ-009 SHALL have ports iocs, iorw  output  1; ioaddr  output  2  SPART bus control (iorw 1 = read).
REQ-010 SHALL have port tx_byte  output  8  value to drive onto the databus; db_oe  output  1  databus drive enable.
REQ-011 SHALL have port rx_byte  input  8  databus value during a read.
REQ-012 SHALL have ports rx_word  output  16  and rx_valid  output  1  assembled receive word with a one-cycle strobe.
REQ-013 SHALL have port busy  output  1  high whenever the state is not IDLE.

Function
REQ-014 SHALL implement states CFG_LO, CFG_HI, IDLE, RX, TX_LO, TX_WAIT and TX_HI.
REQ-015 SHALL leave reset in CFG_LO and drive iocs=1, iorw=0, ioaddr=10, db_oe=1, tx_byte=DIVISOR[7:0] for one cycle, then enter CFG_HI.
REQ-016 SHALL in CFG_HI drive the same with ioaddr=11 and tx_byte=DIVISOR[15:8] for one cycle, then enter IDLE.
REQ-017 SHALL in IDLE and TX_WAIT drive iocs=0, iorw=1, ioaddr=01, db_oe=0, tx_byte=00.
REQ-018 SHALL in IDLE give rda=1 priority: enter RX regardless of req or tbr.
REQ-019 SHALL in IDLE with rda=0, tbr=1 and req!=0 pulse grant to the round-robin winner, latch its word, and enter TX_LO on the next cycle.
REQ-020 SHALL when both requests are active grant the requester not granted last, with requester 0 winning first after reset.
REQ-021 SHALL in RX drive iocs=1, iorw=1, ioaddr=00, db_oe=0 for one cycle and capture rx_byte on that edge.
REQ-022 SHALL store the first captured byte as rx_word[7:0] and the second as rx_word[15:8], then pulse rx_valid for the cycle after the second RX cycle.
REQ-023 SHALL hold rx_word stable until the next complete word.
REQ-024 SHALL discard a stored low byte, with no rx_valid, if RX_TIMEOUT cycles elapse after it without a second RX cycle.
REQ-025 SHALL in TX_LO drive iocs=1, iorw=0, ioaddr=00, db_oe=1, tx_byte=latched[7:0] for one cycle, then enter TX_WAIT.
REQ-026 SHALL stay in TX_WAIT for at least 2 cycles, then until tbr=1, and then enter TX_HI.
REQ-027 SHALL, when rda=1 in TX_WAIT, enter RX and then return to TX_WAIT with the minimum-wait count preserved.
REQ-028 SHALL in TX_HI drive tx_byte=latched[15:8] with the TX_LO controls for one cycle, then enter IDLE.
REQ-029 SHALL never grant while a latched word is unsent.
REQ-030 SHALL ignore req deassertion after grant.
REQ-031 SHALL return to IDLE from any undefined state.

Reset
REQ-032 SHALL on rst=0 immediately force state=CFG_LO, grant=00, rx_valid=0, rx_word=0000, latched word=0000, rx byte count=0, timeout counter=0, round-robin pointer=requester 0.
REQ-033 SHALL abandon any transfer in progress when reset is asserted.
REQ-034 SHALL while rst=0 drive iocs=0, iorw=1, ioaddr=01, db_oe=0, tx_byte=00.

Structure
REQ-035 SHALL place the state enum and the ioaddr constants (DATA=00, STATUS=01, DB_LO=10, DB_HI=11) in a shared package spart_pkg.
REQ-036 SHALL place receive byte pairing and timeout in one sub-module, spart_rx_assembler.

Verification
REQ-037 SHALL check that after reset release the bus shows a write to ioaddr 10 with 0x45, then to 11 with 0x01, then busy=0.
REQ-038 SHALL check that req=01, word0=0xA55A, tbr=1 yields a grant=01 pulse, a data write of 0x5A, at least 2 wait cycles, a data write of 0xA5 after tbr=1, then IDLE.
REQ-039 SHALL check that req=11 held over three words yields grants in the order 01, 10, 01.
REQ-040 SHALL check that rda pulses returning 0x34 then 0x12 yield rx_word=0x1234 and one rx_valid pulse; rda during TX_WAIT is serviced before TX_HI with the transmit bytes unchanged.
REQ-041 SHALL check that a single rx byte 0x77 followed by 1023 idle cycles, then bytes 0xCD and 0xAB, yields rx_word=0xABCD.
REQ-042 SHALL check that rst asserted in TX_WAIT yields no TX_HI write, and that the CFG_LO/CFG_HI sequence restarts.
